// File: rtl/note_sequencer_ctrl_pkg.sv
// Shared types and defaults for the note sequencer.
// NOTE_SEQ_PAUSE_EN adds the PAUSE state, which widens the state register to 3 bits.
package note_seq_pkg;

    localparam int NUM_NOTES_DEF      = 16;
    localparam int TICKS_PER_NOTE_DEF = 25000000;

`ifdef NOTE_SEQ_PAUSE_EN
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        DONE  = 3'd3,
        PAUSE = 3'd4
    } seq_state_t;
`else
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } seq_state_t;
`endif

endpackage

// File: rtl/note_sequencer_ctrl_if.sv
// Key/switch requests in, note RAM / tone generator controls out.
// NOTE_SEQ_PAUSE_EN adds the active-low pause_n request.
interface note_sequencer_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              load_n;
    logic              playback;
    logic              stop_n;
    logic              loop;
    logic [1:0]        tempo_shift;
`ifdef NOTE_SEQ_PAUSE_EN
    logic              pause_n;
`endif
    logic              ld_note;
    logic              ld_play;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              note_strobe;
    logic              seq_done;
    logic              busy;

`ifdef NOTE_SEQ_PAUSE_EN
    modport master (
        output load_n, playback, stop_n, loop, tempo_shift, pause_n,
        input  ld_note, ld_play, wr_addr, rd_addr, note_strobe, seq_done, busy
    );
    modport slave (
        input  load_n, playback, stop_n, loop, tempo_shift, pause_n,
        output ld_note, ld_play, wr_addr, rd_addr, note_strobe, seq_done, busy
    );
`else
    modport master (
        output load_n, playback, stop_n, loop, tempo_shift,
        input  ld_note, ld_play, wr_addr, rd_addr, note_strobe, seq_done, busy
    );
    modport slave (
        input  load_n, playback, stop_n, loop, tempo_shift,
        output ld_note, ld_play, wr_addr, rd_addr, note_strobe, seq_done, busy
    );
`endif

endinterface

// File: rtl/note_sequencer_ctrl_tempo_divider.sv
// Loadable note-period down-counter; reloads itself from period_m1 after reaching zero.
// tick marks the last cycle of a note.
module tempo_divider #(
    parameter int DIV_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] period_m1,
    input  logic             hold,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    // Auto-reload at zero keeps back-to-back notes exactly period_m1+1 cycles apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= period_m1;
        end else if (!hold) begin
            if (r_cnt == '0) r_cnt <= period_m1;
            else             r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = (r_cnt == '0) && !load;

endmodule

// File: rtl/note_sequencer_ctrl.sv
// Note sequencer: load-phase write addressing and timed playback read addressing.
// Optional pause support is compiled in with NOTE_SEQ_PAUSE_EN.
module note_sequencer_ctrl
    import note_seq_pkg::*;
#(
    parameter int NUM_NOTES      = NUM_NOTES_DEF,
    parameter int TICKS_PER_NOTE = TICKS_PER_NOTE_DEF,
    parameter int ADDR_W         = $clog2(NUM_NOTES),
    parameter int DIV_W          = $clog2(TICKS_PER_NOTE)
) (
    input  logic                 clk,
    input  logic                 reset,
    note_sequencer_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NOTES - 1);
    localparam logic [DIV_W-1:0]  PER_M1_0  = DIV_W'(TICKS_PER_NOTE - 1);
    localparam logic [DIV_W-1:0]  PER_M1_1  = DIV_W'((TICKS_PER_NOTE >> 1) - 1);
    localparam logic [DIV_W-1:0]  PER_M1_2  = DIV_W'((TICKS_PER_NOTE >> 2) - 1);
    localparam logic [DIV_W-1:0]  PER_M1_3  = DIV_W'((TICKS_PER_NOTE >> 3) - 1);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_note_strobe;
    logic              r_seq_done;

    logic [DIV_W-1:0]  w_period_m1;
    logic              w_start;
    logic              w_pause;
    logic              w_hold;
    logic              w_tick;
    logic              w_advance;

    always_comb begin
        w_period_m1 = PER_M1_0;
        case (bus.tempo_shift)
            2'd0:    w_period_m1 = PER_M1_0;
            2'd1:    w_period_m1 = PER_M1_1;
            2'd2:    w_period_m1 = PER_M1_2;
            default: w_period_m1 = PER_M1_3;
        endcase
    end

`ifdef NOTE_SEQ_PAUSE_EN
    assign w_pause = !bus.pause_n;
`else
    assign w_pause = 1'b0;
`endif

    // load_n wins over playback, so a start only happens with load_n released.
    assign w_start   = (r_state == IDLE) && bus.load_n && !bus.playback;
    assign w_hold    = (r_state != PLAY) || w_pause;
    assign w_advance = (r_state == PLAY) && bus.stop_n && !w_pause && w_tick &&
                       ((r_rd_addr != LAST_ADDR) || bus.loop);

    tempo_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (w_start),
        .period_m1 (w_period_m1),
        .hold      (w_hold),
        .tick      (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_wr_addr     <= '0;
            r_rd_addr     <= '0;
            r_note_strobe <= 1'b0;
            r_seq_done    <= 1'b0;
        end else begin
            r_note_strobe <= w_start || w_advance;
            r_seq_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!bus.load_n) begin
                        r_state <= LOAD;
                    end else if (!bus.playback) begin
                        r_state   <= PLAY;
                        r_rd_addr <= '0;
                    end
                end
                LOAD: begin
                    if (bus.load_n) begin
                        r_state   <= IDLE;
                        r_wr_addr <= (r_wr_addr == LAST_ADDR) ? '0 : r_wr_addr + 1'b1;
                    end
                end
                PLAY: begin
                    if (!bus.stop_n) begin
                        r_state   <= IDLE;
                        r_rd_addr <= '0;
`ifdef NOTE_SEQ_PAUSE_EN
                    end else if (w_pause) begin
                        r_state <= PAUSE;
`endif
                    end else if (w_tick) begin
                        if (r_rd_addr != LAST_ADDR) begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end else if (bus.loop) begin
                            r_rd_addr <= '0;
                        end else begin
                            r_state    <= DONE;
                            r_seq_done <= 1'b1;
                        end
                    end
                end
                DONE: r_state <= IDLE;
`ifdef NOTE_SEQ_PAUSE_EN
                // Divider is frozen by w_hold; resuming continues the same note.
                PAUSE: begin
                    if (!bus.stop_n) begin
                        r_state   <= IDLE;
                        r_rd_addr <= '0;
                    end else if (!w_pause) begin
                        r_state <= PLAY;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ld_note     = (r_state == LOAD);
    assign bus.ld_play     = (r_state == PLAY);
`ifdef NOTE_SEQ_PAUSE_EN
    assign bus.busy        = (r_state == LOAD) || (r_state == PLAY) || (r_state == PAUSE);
`else
    assign bus.busy        = (r_state == LOAD) || (r_state == PLAY);
`endif
    assign bus.wr_addr     = r_wr_addr;
    assign bus.rd_addr     = r_rd_addr;
    assign bus.note_strobe = r_note_strobe;
    assign bus.seq_done    = r_seq_done;

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
// Bench for note_sequencer_ctrl with NUM_NOTES=4, TICKS_PER_NOTE=8; strobe/done events
// are scoreboarded against hand-computed cycle stamps. Pause test needs NOTE_SEQ_PAUSE_EN.
module tb_note_sequencer_ctrl;

    typedef struct {
        bit         done;
        logic [1:0] addr;
        int         cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    ev_t  sbq[$];

    note_sequencer_ctrl_if #(.ADDR_W(2)) bus ();

    note_sequencer_ctrl #(
        .NUM_NOTES      (4),
        .TICKS_PER_NOTE (8)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_ev(input bit d, input logic [1:0] a, input int c);
        ev_t e;
        e.done = d;
        e.addr = a;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    // Monitor: every strobe / done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (bus.note_strobe || bus.seq_done)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_event", int'(bus.note_strobe) * 2 + int'(bus.seq_done), 0);
            end else begin
                ev_t e;
                e = sbq.pop_front();
                chk("ev_kind_done", int'(bus.seq_done), int'(e.done));
                chk("ev_cycle", cyc, e.cyc);
                if (!e.done) chk("ev_rd_addr", int'(bus.rd_addr), int'(e.addr));
            end
        end
    end

    initial begin
        int k;
        int n;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.load_n      = 1'b1;
        bus.playback    = 1'b1;
        bus.stop_n      = 1'b1;
        bus.loop        = 1'b0;
        bus.tempo_shift = 2'd0;
`ifdef NOTE_SEQ_PAUSE_EN
        bus.pause_n     = 1'b1;
`endif
        #12;
        chk("rst_ld_note", int'(bus.ld_note), 0);
        chk("rst_ld_play", int'(bus.ld_play), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_rd_addr", int'(bus.rd_addr), 0);
        chk("rst_strobe", int'(bus.note_strobe), 0);
        chk("rst_done", int'(bus.seq_done), 0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Four 3-cycle load pulses: wr_addr 1,2,3 then wraps to 0.
        for (int p = 0; p < 4; p++) begin
            n = 0;
            bus.load_n = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step(1);
                if (i == 2) bus.load_n = 1'b1;
                n += int'(bus.ld_note);
            end
            chk("load_ld_note_cycles", n, 3);
            chk("load_wr_addr", int'(bus.wr_addr), (p + 1) % 4);
        end

        // Single pass, 8-cycle notes.
        k = cyc;
        bus.playback = 1'b0;
        exp_ev(0, 2'd0, k + 1);
        exp_ev(0, 2'd1, k + 9);
        exp_ev(0, 2'd2, k + 17);
        exp_ev(0, 2'd3, k + 25);
        exp_ev(1, 2'd0, k + 33);
        step(1);
        bus.playback = 1'b1;
        chk("play_ld_play", int'(bus.ld_play), 1);
        chk("play_busy", int'(bus.busy), 1);
        chk("play_ld_note", int'(bus.ld_note), 0);
        step(32);
        chk("done_ld_play", int'(bus.ld_play), 0);
        step(1);
        chk("idle_busy", int'(bus.busy), 0);

        // Loop with 4-cycle notes, then abort.
        bus.loop        = 1'b1;
        bus.tempo_shift = 2'd1;
        k = cyc;
        bus.playback = 1'b0;
        exp_ev(0, 2'd0, k + 1);
        exp_ev(0, 2'd1, k + 5);
        exp_ev(0, 2'd2, k + 9);
        exp_ev(0, 2'd3, k + 13);
        exp_ev(0, 2'd0, k + 17);
        exp_ev(0, 2'd1, k + 21);
        step(1);
        bus.playback = 1'b1;
        step(21);
        chk("loop_rd_before_stop", int'(bus.rd_addr), 1);
        bus.stop_n = 1'b0;
        step(1);
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_ld_play", int'(bus.ld_play), 0);
        chk("stop_rd_addr", int'(bus.rd_addr), 0);
        bus.stop_n      = 1'b1;
        bus.loop        = 1'b0;
        bus.tempo_shift = 2'd0;
        step(2);

        // Simultaneous requests: load wins.
        bus.load_n   = 1'b0;
        bus.playback = 1'b0;
        step(1);
        chk("both_ld_note", int'(bus.ld_note), 1);
        chk("both_ld_play", int'(bus.ld_play), 0);
        bus.load_n   = 1'b1;
        bus.playback = 1'b1;
        step(1);
        chk("both_ld_note_end", int'(bus.ld_note), 0);
        chk("both_wr_addr", int'(bus.wr_addr), 1);
        step(1);

        // Mid-note tempo change only affects the following notes.
        k = cyc;
        bus.playback = 1'b0;
        exp_ev(0, 2'd0, k + 1);
        exp_ev(0, 2'd1, k + 9);
        exp_ev(0, 2'd2, k + 11);
        exp_ev(0, 2'd3, k + 13);
        exp_ev(1, 2'd0, k + 15);
        step(1);
        bus.playback = 1'b1;
        step(3);
        bus.tempo_shift = 2'd2;
        step(12);
        chk("tempo_idle_busy", int'(bus.busy), 0);
        bus.tempo_shift = 2'd0;
        step(1);

        // Asynchronous reset in the middle of the second note.
        k = cyc;
        bus.playback = 1'b0;
        exp_ev(0, 2'd0, k + 1);
        exp_ev(0, 2'd1, k + 9);
        step(1);
        bus.playback = 1'b1;
        step(11);
        chk("pre_rst_rd_addr", int'(bus.rd_addr), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ld_play", int'(bus.ld_play), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_rd_addr", int'(bus.rd_addr), 0);
        chk("arst_wr_addr", int'(bus.wr_addr), 0);
        chk("arst_strobe", int'(bus.note_strobe), 0);
        chk("arst_ld_note", int'(bus.ld_note), 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_busy", int'(bus.busy), 0);
        chk("post_rst_wr_addr", int'(bus.wr_addr), 0);

`ifdef NOTE_SEQ_PAUSE_EN
        // Pause at divider=3 for 5 cycles; the note resumes with 4 cycles left.
        k = cyc;
        bus.playback = 1'b0;
        exp_ev(0, 2'd0, k + 1);
        step(1);
        bus.playback = 1'b1;
        step(4);
        bus.pause_n = 1'b0;
        exp_ev(0, 2'd1, k + 15);
        exp_ev(0, 2'd2, k + 23);
        exp_ev(0, 2'd3, k + 31);
        exp_ev(1, 2'd0, k + 39);
        step(2);
        chk("pause_ld_play", int'(bus.ld_play), 0);
        chk("pause_rd_addr", int'(bus.rd_addr), 0);
        chk("pause_busy", int'(bus.busy), 1);
        step(3);
        bus.pause_n = 1'b1;
        step(30);
        chk("pause_end_busy", int'(bus.busy), 0);
`endif

        step(5);
        chk("sb_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
